// File: rtl/pipl_hazard_ctrl.sv
// Stall/flush sequencer driving the en/nop pair of every pipeline register and the PC enable.
// Latency: en/nop outputs are combinational; state, mc_cnt and counters update on the next rising edge.
// Backpressure: mem_wait freezes every stage, load-use and multi-cycle EX ops stall the front, taken branches flush.
module pipl_hazard_ctrl #(
    parameter int MulLat  = 4,
    parameter int CntBits = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_rs_used,
    input  logic               id_rt_used,
    input  logic               ex_load,
    input  logic [4:0]         ex_rd,
    input  logic               ex_branch_taken,
    input  logic               ex_mcyc,
    input  logic               mem_wait,
    input  logic               wb_halt,
    input  logic               resume,
    output logic               pc_en,
    output logic               ifid_en,
    output logic               ifid_nop,
    output logic               idex_en,
    output logic               idex_nop,
    output logic               exma_en,
    output logic               exma_nop,
    output logic               mawb_en,
    output logic               mawb_nop,
    output logic               halted,
    output logic [CntBits-1:0] stall_cnt,
    output logic [CntBits-1:0] flush_cnt
);

    localparam int             McW    = (MulLat > 1) ? $clog2(MulLat) : 1;
    localparam logic [McW-1:0] McLast = McW'(MulLat - 1);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [McW-1:0]     mc_cnt_q, mc_cnt_d;
    logic [CntBits-1:0] stall_cnt_q, stall_cnt_d;
    logic [CntBits-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic hold_ex;

    // Hazard detection: register 0 is never a real dependency.
    always_comb begin
        load_use = ex_load && (ex_rd != 5'd0) &&
                   ((id_rs_used && (id_rs == ex_rd)) || (id_rt_used && (id_rt == ex_rd)));
        hold_ex  = ex_mcyc && (mc_cnt_q != McLast);
    end

    // Next-state and per-stage control, highest-priority condition first; reset forces all controls low.
    always_comb begin
        state_d     = state_q;
        mc_cnt_d    = mc_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_nop    = 1'b0;
        idex_en     = 1'b0;
        idex_nop    = 1'b0;
        exma_en     = 1'b0;
        exma_nop    = 1'b0;
        mawb_en     = 1'b0;
        mawb_nop    = 1'b0;
        halted      = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    stall_cnt_d = stall_cnt_q + CntBits'(1);
                end else if (wb_halt) begin
                    // Bubble into WB so the halt instruction does not retire twice.
                    mawb_en     = 1'b1;
                    mawb_nop    = 1'b1;
                    state_d     = HALTED;
                    stall_cnt_d = stall_cnt_q + CntBits'(1);
                end else if (hold_ex) begin
                    // EX keeps its op; MA receives bubbles while older work drains to WB.
                    exma_en     = 1'b1;
                    exma_nop    = 1'b1;
                    mawb_en     = 1'b1;
                    mc_cnt_d    = mc_cnt_q + McW'(1);
                    stall_cnt_d = stall_cnt_q + CntBits'(1);
                end else begin
                    // Any multi-cycle op in EX is on its final cycle and advances.
                    mc_cnt_d = '0;
                    if (ex_branch_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        ifid_nop    = 1'b1;
                        idex_en     = 1'b1;
                        idex_nop    = 1'b1;
                        exma_en     = 1'b1;
                        mawb_en     = 1'b1;
                        flush_cnt_d = flush_cnt_q + CntBits'(1);
                    end else if (load_use) begin
                        idex_en     = 1'b1;
                        idex_nop    = 1'b1;
                        exma_en     = 1'b1;
                        mawb_en     = 1'b1;
                        stall_cnt_d = stall_cnt_q + CntBits'(1);
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        idex_en = 1'b1;
                        exma_en = 1'b1;
                        mawb_en = 1'b1;
                    end
                end
            end
            HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            ifid_nop = 1'b0;
            idex_en  = 1'b0;
            idex_nop = 1'b0;
            exma_en  = 1'b0;
            exma_nop = 1'b0;
            mawb_en  = 1'b0;
            mawb_nop = 1'b0;
            halted   = 1'b0;
        end
    end

    // State, multi-cycle counter and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipl_hazard_ctrl.sv
// Directed bench for pipl_hazard_ctrl with MulLat=4 and 4-bit counters.
// Inputs change 1ns after a rising edge; controls are checked before the next edge, counters just after it.
// Every comparison is an immediate assertion that counts and reports its own failure.
module tb_pipl_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_rs_used, id_rt_used, ex_load, ex_branch_taken, ex_mcyc;
    logic       mem_wait, wb_halt, resume;
    logic       pc_en, ifid_en, ifid_nop, idex_en, idex_nop;
    logic       exma_en, exma_nop, mawb_en, mawb_nop, halted;
    logic [3:0] stall_cnt, flush_cnt;
    logic [9:0] ctrl;

    int errors = 0;
    int checks = 0;

    // {pc_en, ifid_en, ifid_nop, idex_en, idex_nop, exma_en, exma_nop, mawb_en, mawb_nop, halted}
    localparam logic [9:0] C_OFF   = 10'b0000000000;
    localparam logic [9:0] C_NORM  = 10'b1101010100;
    localparam logic [9:0] C_LU    = 10'b0001110100;
    localparam logic [9:0] C_BR    = 10'b1111110100;
    localparam logic [9:0] C_HOLD  = 10'b0000011100;
    localparam logic [9:0] C_HREQ  = 10'b0000000110;
    localparam logic [9:0] C_HALT  = 10'b0000000001;

    pipl_hazard_ctrl #(.MulLat(4), .CntBits(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_load(ex_load), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken), .ex_mcyc(ex_mcyc),
        .mem_wait(mem_wait), .wb_halt(wb_halt), .resume(resume),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_nop(ifid_nop), .idex_en(idex_en), .idex_nop(idex_nop),
        .exma_en(exma_en), .exma_nop(exma_nop), .mawb_en(mawb_en), .mawb_nop(mawb_nop),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctrl = {pc_en, ifid_en, ifid_nop, idex_en, idex_nop, exma_en, exma_nop, mawb_en, mawb_nop, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; ex_load = 1'b0;
        ex_branch_taken = 1'b0; ex_mcyc = 1'b0;
        mem_wait = 1'b0; wb_halt = 1'b0; resume = 1'b0;
    endtask

    task automatic set_lu;
        ex_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_rs_used = 1'b1;
    endtask

    // One cycle: controls checked mid-cycle, counters checked after the edge.
    task automatic cyc(input string tag, input logic [9:0] ec, input int es, input int ef);
        #1;
        chk({tag, "_ctrl"}, 32'(ctrl), 32'(ec));
        tick();
        chk({tag, "_stall"}, 32'(stall_cnt), 32'(es));
        chk({tag, "_flush"}, 32'(flush_cnt), 32'(ef));
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(C_OFF));
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);
        tick();
        rst = 1'b0;
        cyc("norm0", C_NORM, 0, 0);

        // Load-use detection
        set_lu();
        cyc("lu_rs", C_LU, 1, 0);
        id_rs_used = 1'b0; id_rt = 5'd8; id_rt_used = 1'b1;
        cyc("lu_rt", C_LU, 2, 0);
        id_rt_used = 1'b0;
        cyc("lu_unused", C_NORM, 2, 0);
        id_rs = 5'd0; id_rs_used = 1'b1; ex_rd = 5'd0;
        cyc("lu_r0", C_NORM, 2, 0);
        id_rs = 5'd9; ex_rd = 5'd8;
        cyc("lu_nomatch", C_NORM, 2, 0);
        idle();

        // Multi-cycle op: 3 holds then advance
        ex_mcyc = 1'b1;
        cyc("mc1", C_HOLD, 3, 0);
        cyc("mc2", C_HOLD, 4, 0);
        cyc("mc3", C_HOLD, 5, 0);
        cyc("mc4", C_NORM, 5, 0);
        ex_mcyc = 1'b0;
        cyc("mc_after", C_NORM, 5, 0);

        // Multi-cycle op with a memory wait on cycle 2
        ex_mcyc = 1'b1;
        cyc("mcw1", C_HOLD, 6, 0);
        mem_wait = 1'b1;
        cyc("mcw2_wait", C_OFF, 7, 0);
        mem_wait = 1'b0;
        cyc("mcw3", C_HOLD, 8, 0);
        cyc("mcw4", C_HOLD, 9, 0);
        cyc("mcw5", C_NORM, 9, 0);
        idle();

        // Branch beats load-use; hold beats branch
        ex_branch_taken = 1'b1; set_lu();
        cyc("br_lu", C_BR, 9, 1);
        idle();
        ex_mcyc = 1'b1; ex_branch_taken = 1'b1;
        cyc("br_hold1", C_HOLD, 10, 1);
        ex_branch_taken = 1'b0;
        cyc("br_hold2", C_HOLD, 11, 1);
        cyc("br_hold3", C_HOLD, 12, 1);
        cyc("br_hold4", C_NORM, 12, 1);
        idle();
        ex_branch_taken = 1'b1;
        cyc("br_plain", C_BR, 12, 2);
        mem_wait = 1'b1;
        cyc("br_wait", C_OFF, 13, 2);
        idle();

        // Halt, ten frozen cycles with noisy inputs, resume
        wb_halt = 1'b1;
        cyc("halt_req", C_HREQ, 14, 2);
        for (int i = 0; i < 10; i++) begin
            idle();
            ex_mcyc = i[0]; mem_wait = i[1]; wb_halt = i[2];
            ex_branch_taken = i[0]; set_lu();
            cyc("halted", C_HALT, 14, 2);
        end
        idle();
        resume = 1'b1;
        cyc("resume", C_HALT, 14, 2);
        resume = 1'b0;
        cyc("post_resume", C_NORM, 14, 2);

        // Reset mid multi-cycle op (stall wraps 15 -> 0 on the way)
        ex_mcyc = 1'b1;
        cyc("pre_rst1", C_HOLD, 15, 2);
        cyc("pre_rst2", C_HOLD, 0, 2);
        rst = 1'b1;
        #1;
        chk("rst_mc_ctrl", 32'(ctrl), 32'(C_OFF));
        chk("rst_mc_stall", 32'(stall_cnt), 32'd0);
        chk("rst_mc_flush", 32'(flush_cnt), 32'd0);
        tick();
        rst = 1'b0;
        cyc("mcr1", C_HOLD, 1, 0);
        cyc("mcr2", C_HOLD, 2, 0);
        cyc("mcr3", C_HOLD, 3, 0);
        cyc("mcr4", C_NORM, 3, 0);
        idle();

        // Reset while halted
        wb_halt = 1'b1;
        cyc("halt_req2", C_HREQ, 4, 0);
        wb_halt = 1'b0;
        cyc("halted2", C_HALT, 4, 0);
        rst = 1'b1;
        #1;
        chk("rst_halt_ctrl", 32'(ctrl), 32'(C_OFF));
        chk("rst_halt_stall", 32'(stall_cnt), 32'd0);
        tick();
        rst = 1'b0;
        cyc("rst_halt_run", C_NORM, 0, 0);

        // 17 load-use stalls wrap the 4-bit counter to 1
        set_lu();
        for (int i = 0; i < 17; i++) begin
            cyc("wrap", C_LU, (i + 1) % 16, 0);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipl_hazard_ctrl.md
Name: pipl_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the en/nop pair of every pipeline interface register (IF/ID, ID/EX, EX/MA, MA/WB) plus the PC write enable.
- Detects load-use hazards, sequences multi-cycle EX operations, flushes on taken branches, freezes on memory wait and runs the halt/resume state machine.
- Keeps stall and flush performance counters.

Parameters:
MulLat, 4, total cycles a multi-cycle op occupies EX (>=1; 1 = no hold)
CntBits, 32, width of performance counters

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
id_rs  input  5  ID-stage source register rs
id_rt  input  5  ID-stage source register rt
id_rs_used  input  1  ID instruction reads rs
id_rt_used  input  1  ID instruction reads rt
ex_load  input  1  EX instruction is a load
ex_rd  input  5  EX instruction destination register
ex_branch_taken  input  1  EX resolved a taken branch/jump
ex_mcyc  input  1  EX holds a multi-cycle op (level, every cycle it sits in EX)
mem_wait  input  1  data memory not ready
wb_halt  input  1  halt instruction in WB this cycle
resume  input  1  leave HALTED
pc_en  output  1  PC write enable
ifid_en, ifid_nop  output  1 each  IF/ID interface control
idex_en, idex_nop  output  1 each  ID/EX interface control
exma_en, exma_nop  output  1 each  EX/MA interface control
mawb_en, mawb_nop  output  1 each  MA/WB interface control
halted  output  1  state==HALTED
stall_cnt  output  CntBits  cycles with pc_en==0 in RUN
flush_cnt  output  CntBits  taken-branch flushes

Behaviour:
- States: RUN, HALTED. The only registers are the state, mc_cnt (0..MulLat-1) and the two counters.
- en/nop outputs are combinational from state, mc_cnt and inputs. While rst is high, all en=0, all nop=0, halted=0.
- Reset: state=RUN, mc_cnt=0, counters=0. A reset mid-multi-cycle-op or mid-halt discards it.
- load_use = ex_load & ex_rd!=0 & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)).
- hold_ex = ex_mcyc & mc_cnt!=MulLat-1.
- Priority in RUN (first match wins):
  1. mem_wait: all en=0. mc_cnt and counters frozen, except stall_cnt increments.
  2. wb_halt: pc/ifid/idex/exma en=0; mawb_en=1, mawb_nop=1 (bubble clears halt from WB); next state HALTED.
  3. hold_ex: pc/ifid/idex en=0; exma_en=1, exma_nop=1; mawb_en=1, mawb_nop=0; mc_cnt++. ex_branch_taken is ignored.
  4. ex_branch_taken: all en=1; ifid_nop=1, idex_nop=1, others 0; flush_cnt++. Overrides load_use, whose ID instruction is wrong-path.
  5. load_use: pc/ifid en=0; idex_en=1, idex_nop=1; exma/mawb en=1, nop=0.
  6. Normal: all en=1, all nop=0.
- mc_cnt: when ex_mcyc & mc_cnt==MulLat-1 and no mem_wait/wb_halt, clear to 0 and advance normally. An op therefore spends exactly MulLat non-wait cycles in EX. With MulLat=1, ex_mcyc never holds.
- HALTED: all en=0, nop=0, halted=1. No counters change. resume → RUN next edge, with no extra bubble. wb_halt is ignored in HALTED.
- stall_cnt increments on every RUN cycle with pc_en==0, including rules 1, 2, 3 and 5.
- Counters wrap modulo 2^CntBits; no saturation.

Test Plan:
- Load-use: ex_load=1, ex_rd=8, id_rs=8, id_rs_used=1 → pc_en=0, ifid_en=0, idex_en=1, idex_nop=1 for one cycle; stall_cnt 0→1. Repeat with ex_rd=0 → normal, no stall.
- Multi-cycle (MulLat=4): ex_mcyc held 4 cycles → 3 cycles of pc_en=0, exma_nop=1, then a normal advance on cycle 4; stall_cnt=3. mem_wait inserted on cycle 2 extends the sequence to 5 cycles, and mc_cnt does not move during the wait.
- Branch + load_use same cycle → ifid_nop=idex_nop=1, pc_en=1, flush_cnt=1, stall_cnt unchanged. Branch while hold_ex → branch ignored.
- Halt: wb_halt=1 → mawb_en=1, mawb_nop=1, others en=0; then halted=1 with all en=0 for 10 cycles, counters constant. resume → halted=0 next cycle, normal enables.
- Counter wrap (CntBits=4): 17 load-use stalls → stall_cnt=1.
- Async reset asserted mid-multi-cycle op and while HALTED → immediate en=0, halted=0, counters 0; after release, ex_mcyc restarts a full MulLat sequence.
